// File: rtl/btn_pkg.sv
// btn_pkg: shared types and defaults for the push-button front end.
// Holds the press-tracking state enum and the board default timing.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } btn_state_t;

   // 100 MHz / 65536 gives a ~655 us sample period.
   localparam int BTN_SAMPLE_DIV       = 65536;
   localparam int BTN_DEBOUNCE_SAMPLES = 4;
   // ~1 s of hold at the default sample rate.
   localparam int BTN_LONG_TICKS       = 1526;

   // Counter width for a modulo-n counter, never below one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: synchronizes the raw button, divides the clock into
// sample ticks and turns a run of equal samples into a clean level.
module debounce_filter
   import btn_pkg::*;
#(
   parameter int SAMPLE_DIV       = BTN_SAMPLE_DIV,
   parameter int DEBOUNCE_SAMPLES = BTN_DEBOUNCE_SAMPLES
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_in,
   output logic pb_level,
   output logic tick
);

   localparam int DW = cnt_width(SAMPLE_DIV);
   localparam int NS = DEBOUNCE_SAMPLES;
   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

   logic [1:0]    sync_q;
   logic          pb_sync;
   logic [DW-1:0] div_cnt;
   logic [NS-1:0] shift_q;
   logic [NS-1:0] shift_nxt;

   assign pb_sync   = sync_q[1];
   assign tick      = (div_cnt == DIV_LAST);
   assign shift_nxt = {shift_q[NS-2:0], pb_sync};

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pb_in};
      end
   end

   // Free-running sample divider; tick marks its last count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // Sample history; the level only moves on a unanimous history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q  <= '0;
         pb_level <= 1'b0;
      end else if (tick) begin
         shift_q <= shift_nxt;
         if (&shift_nxt) begin
            pb_level <= 1'b1;
         end else if (~|shift_nxt) begin
            pb_level <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced level plus press, short-release and
// long-hold single-cycle pulses for one lab-board push-button.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int SAMPLE_DIV       = BTN_SAMPLE_DIV,
   parameter int DEBOUNCE_SAMPLES = BTN_DEBOUNCE_SAMPLES,
   parameter int LONG_TICKS       = BTN_LONG_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_in,
   output logic pb_level,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse
);

   localparam int HW = cnt_width(LONG_TICKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

   logic          tick;
   logic          level_d;
   logic          rel;
   logic          hold_done;
   btn_state_t    state_q;
   btn_state_t    state_d;
   logic [HW-1:0] hold_q;
   logic [HW-1:0] hold_d;
   logic          short_d;
   logic          long_d;

   debounce_filter #(
      .SAMPLE_DIV       (SAMPLE_DIV),
      .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
   ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .pb_in    (pb_in),
      .pb_level (pb_level),
      .tick     (tick)
   );

   assign press_pulse = pb_level & ~level_d;
   assign rel         = ~pb_level & level_d;
   assign hold_done   = (hold_q == HOLD_LAST);

   // One-clock delayed level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
      end else begin
         level_d <= pb_level;
      end
   end

   // State, hold counter and registered event pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         short_pulse <= short_d;
         long_pulse  <= long_d;
      end
   end

   // Next state; a release beats a coincident tick.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (press_pulse) begin
               state_d = PRESSED;
               hold_d  = '0;
            end
         end
         PRESSED: begin
            if (rel) begin
               state_d = IDLE;
            end else if (tick) begin
               if (hold_done) begin
                  state_d = LONG_HELD;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         LONG_HELD: begin
            if (rel) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pulse requests, registered on the following edge.
   always_comb begin
      short_d = 1'b0;
      long_d  = 1'b0;
      if (state_q == PRESSED) begin
         short_d = rel;
         long_d  = ~rel & tick & hold_done;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with
// small divider settings; expected pulses are queued at stimulus time.
module tb_button_conditioner;

   localparam int SDIV = 4;
   localparam int NSMP = 4;
   localparam int LT   = 8;

   logic clk;
   logic rst;
   logic pb_in;
   logic pb_level;
   logic press_pulse;
   logic short_pulse;
   logic long_pulse;

   typedef struct {
      int kind;
      int lo;
      int hi;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   mon_code;
   int   cyc;
   int   last_press;
   int   n_chk;
   int   n_fail;

   button_conditioner #(
      .SAMPLE_DIV       (SDIV),
      .DEBOUNCE_SAMPLES (NSMP),
      .LONG_TICKS       (LT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pb_in       (pb_in),
      .pb_level    (pb_level),
      .press_pulse (press_pulse),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse)
   );

   // 10 ns system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle stamp used for pulse timing windows.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input int lo, input int hi);
      exp_t e;
      e.kind = kind;
      e.lo   = lo;
      e.hi   = hi;
      sbq.push_back(e);
   endtask

   // kind codes: 1 press, 2 short, 4 long.
   task automatic short_press(input int hold);
      int k;
      k = cyc;
      push(1, k + 14, k + 19);
      pb_in = 1'b1;
      clocks(hold);
      push(2, cyc + 15, cyc + 20);
      pb_in = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         clocks(1);
         n++;
      end
      check(tag, sbq.size(), 0);
      sbq.delete();
   endtask

   // Every pulse is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (press_pulse || short_pulse || long_pulse)) begin
         mon_code = int'({long_pulse, short_pulse, press_pulse});
         check("one_hot", $countones({long_pulse, short_pulse,
                                      press_pulse}), 1);
         if (sbq.size() == 0) begin
            check("unexpected_pulse", mon_code, 0);
         end else begin
            mon_e = sbq.pop_front();
            check("pulse_kind", mon_code, mon_e.kind);
            check("pulse_window",
                  int'(cyc >= mon_e.lo && cyc <= mon_e.hi), 1);
            if (long_pulse) begin
               check("long_gap", cyc - last_press, 32);
            end
            if (press_pulse) begin
               last_press = cyc;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int acc;
      int k;
      int r;
      int n;
      n_chk      = 0;
      n_fail     = 0;
      last_press = 0;
      rst        = 1'b1;
      pb_in      = 1'b1;

      // Reset state with the button held.
      clocks(3);
      @(negedge clk);
      check("rst_level", int'(pb_level), 0);
      check("rst_press", int'(press_pulse), 0);
      check("rst_short", int'(short_pulse), 0);
      check("rst_long", int'(long_pulse), 0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      pb_in = 1'b0;
      acc   = 0;
      repeat (100) begin
         @(negedge clk);
         acc |= int'({pb_level, press_pulse, short_pulse, long_pulse});
      end
      check("idle_100", acc, 0);
      @(posedge clk);
      #1;

      // Clean short press.
      short_press(20);
      wait_drain("short_drain", 60);
      clocks(20);

      // Bounce then settle high.
      for (int i = 0; i < 12; i++) begin
         pb_in = ~i[0];
         clocks(5);
      end
      short_press(20);
      wait_drain("bounce_drain", 60);
      clocks(20);

      // Long press held for 200 clocks.
      k = cyc;
      push(1, k + 14, k + 19);
      push(4, k + 46, k + 51);
      pb_in = 1'b1;
      clocks(200);
      pb_in = 1'b0;
      wait_drain("long_drain", 60);
      clocks(40);

      // Reset at hold tick 5 while the button stays down.
      k = cyc;
      push(1, k + 14, k + 19);
      pb_in = 1'b1;
      wait_drain("rmp_press", 40);
      n = 0;
      while (cyc < last_press + 20 && n < 40) begin
         clocks(1);
         n++;
      end
      rst = 1'b1;
      #1;
      check("rmp_async_level", int'(pb_level), 0);
      clocks(3);
      rst = 1'b0;
      r   = cyc;
      push(1, r + 14, r + 19);
      clocks(20);
      push(2, cyc + 15, cyc + 20);
      pb_in = 1'b0;
      wait_drain("rmp_repress", 60);
      clocks(20);

      // Back-to-back short presses.
      short_press(20);
      clocks(20);
      short_press(20);
      wait_drain("b2b_drain", 80);
      clocks(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
